nco_sched: RTL and testbench

Time-division scheduler that shares one `nco` instance between `NCH` independent channels. It holds a per-channel phase increment and phase accumulator, and issues angles to the NCO round-robin over its angle req/ack port. A tag FIFO records each issued channel so the NCO results returned in order are labelled with their channel and forwarded on a single sample stream.

---
 rtl/nco_sched.sv | 133 +++++++++++++
 tb/tb_nco_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sched.sv
// Round-robin scheduler that shares one NCO between NCH phase accumulators and labels the in-order results with their channel.
// Latency: enable->angle 1 cycle, result->sample 1 cycle; issue stalls on angle ack or tag credit, results stall on sample ack.
module nco_sched #(
  parameter int NCH   = 4,
  parameter int W     = 32,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(NCH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_inc,
  input  logic          cfg_en,
  input  logic          cfg_clr,
  output logic [W-1:0]  i_angle_dat,
  output logic          i_angle_req,
  input  logic          i_angle_ack,
  input  logic [W-1:0]  t_nco_dat,
  input  logic          t_nco_req,
  output logic          t_nco_ack,
  output logic [W-1:0]  i_smp_dat,
  output logic [CW-1:0] i_smp_ch,
  output logic          i_smp_req,
  input  logic          i_smp_ack,
  output logic          err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]     state;
  logic [W-1:0]   inc     [NCH];
  logic [W-1:0]   acc     [NCH];
  logic [W-1:0]   acc_nxt [NCH];
  logic [NCH-1:0] en;
  logic [CW-1:0]  last, sel, base, cand, nsel;
  logic           found;
  logic [CW-1:0]  tag_mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    cnt, cnt_nxt;
  logic           ang_xfer, res_xfer, pop, load;

  assign i_angle_req = (state == HOLD);
  assign t_nco_ack   = !i_smp_req || i_smp_ack;
  assign ang_xfer    = i_angle_req && i_angle_ack;
  assign res_xfer    = t_nco_req && t_nco_ack;
  assign pop         = res_xfer && (cnt != '0);

  // Credit is judged on the post-edge occupancy so a reload never overfills the tag FIFO.
  always_comb begin
    cnt_nxt = cnt + {{AW{1'b0}}, ang_xfer} - {{AW{1'b0}}, pop};
    base    = ang_xfer ? sel : last;
    cand    = '0;
    nsel    = '0;
    found   = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      cand = base + CW'(i);
      if (!found && en[cand]) begin
        found = 1'b1;
        nsel  = cand;
      end
    end
    load = ((state == IDLE) || ang_xfer) && found && (cnt_nxt < (AW+1)'(DEPTH));
  end

  // A clear on the channel being transferred overrides its increment.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      acc_nxt[c] = acc[c];
      if (ang_xfer && sel == CW'(c))
        acc_nxt[c] = acc[c] + inc[c];
      if (cfg_we && cfg_clr && cfg_ch == CW'(c))
        acc_nxt[c] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      i_angle_dat <= '0;
      sel         <= '0;
      last        <= CW'(NCH - 1);
      en          <= '0;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      i_smp_req   <= 1'b0;
      i_smp_dat   <= '0;
      i_smp_ch    <= '0;
      err         <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        acc[c] <= '0;
        inc[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++)
        acc[c] <= acc_nxt[c];
      if (cfg_we) begin
        inc[cfg_ch] <= cfg_inc;
        en[cfg_ch]  <= cfg_en;
      end
      if (ang_xfer) begin
        last   <= sel;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        state       <= HOLD;
        sel         <= nsel;
        i_angle_dat <= acc_nxt[nsel];
      end else if (ang_xfer) begin
        state <= IDLE;
      end
      cnt <= cnt_nxt;
      if (res_xfer && cnt == '0)
        err <= 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        i_smp_req <= 1'b1;
        i_smp_dat <= t_nco_dat;
        i_smp_ch  <= tag_mem[rd_ptr];
      end else if (i_smp_ack) begin
        i_smp_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ang_xfer)
      tag_mem[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_nco_sched.sv
// Bench for nco_sched: NCO stub with latency 3, per-cycle reference model, directed and random phases.
module tb_nco_sched;
  localparam int NCH = 4, W = 32, DEPTH = 8, CW = 2;

  logic          clk = 1'b0, reset = 1'b1;
  logic          cfg_we = 1'b0, cfg_en = 1'b0, cfg_clr = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [W-1:0]  cfg_inc = '0;
  logic [W-1:0]  i_angle_dat, t_nco_dat = '0, i_smp_dat;
  logic          i_angle_req, i_angle_ack = 1'b1, t_nco_req = 1'b0, t_nco_ack;
  logic [CW-1:0] i_smp_ch;
  logic          i_smp_req, i_smp_ack = 1'b1, err;

  always #5 clk = ~clk;

  nco_sched #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
    .cfg_en(cfg_en), .cfg_clr(cfg_clr), .i_angle_dat(i_angle_dat), .i_angle_req(i_angle_req),
    .i_angle_ack(i_angle_ack), .t_nco_dat(t_nco_dat), .t_nco_req(t_nco_req), .t_nco_ack(t_nco_ack),
    .i_smp_dat(i_smp_dat), .i_smp_ch(i_smp_ch), .i_smp_req(i_smp_req), .i_smp_ack(i_smp_ack),
    .err(err));

  int errs = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model, stepped at every falling edge ----------------
  logic [W-1:0] m_acc [NCH], m_inc [NCH], nacc [NCH];
  logic [NCH-1:0] m_en;
  int  m_last, m_sel, m_smp_ch, base, pre, ch;
  bit  m_hold, m_smp_req, m_err, started = 0, ax, rx, can;
  logic [W-1:0] m_ang, m_smp_dat;
  int  tagq[$];

  bit ax_seen = 0, rx_seen = 0, rst_seen = 1;
  logic [W-1:0] ax_dat;
  int cyc = 0;
  logic [W-1:0] ang_log[$], smp_dat_log[$];
  int ang_cyc[$], smp_ch_log[$];

  always @(negedge clk) begin
    if (started) begin
      chk("t_nco_ack", t_nco_ack, !m_smp_req || i_smp_ack);
      chk("angle_req", i_angle_req, m_hold);
      if (m_hold) chk("angle_dat", i_angle_dat, m_ang);
      chk("smp_req", i_smp_req, m_smp_req);
      if (m_smp_req) begin
        chk("smp_dat", i_smp_dat, m_smp_dat);
        chk("smp_ch", 32'(i_smp_ch), 32'(m_smp_ch));
      end
      chk("err", err, m_err);
    end
    ax_seen  = i_angle_req && i_angle_ack;
    ax_dat   = i_angle_dat;
    rx_seen  = t_nco_req && t_nco_ack;
    rst_seen = reset;
    if (ax_seen) begin ang_log.push_back(i_angle_dat); ang_cyc.push_back(cyc); end
    if (i_smp_req && i_smp_ack) begin smp_ch_log.push_back(int'(i_smp_ch)); smp_dat_log.push_back(i_smp_dat); end

    if (reset) begin
      for (int c = 0; c < NCH; c++) begin m_acc[c] = '0; m_inc[c] = '0; end
      m_en = '0; m_last = NCH - 1; m_sel = 0; m_hold = 0; m_ang = '0;
      tagq.delete(); m_smp_req = 0; m_smp_dat = '0; m_smp_ch = 0; m_err = 0;
      started = 1;
    end else begin
      ax  = m_hold && i_angle_ack;
      rx  = t_nco_req && (!m_smp_req || i_smp_ack);
      pre = tagq.size();
      for (int c = 0; c < NCH; c++) nacc[c] = m_acc[c];
      if (ax) nacc[m_sel] = m_acc[m_sel] + m_inc[m_sel];
      if (cfg_we && cfg_clr) nacc[cfg_ch] = '0;
      base = ax ? m_sel : m_last;
      can  = (!m_hold || ax) && ((pre + int'(ax) - int'(rx && pre > 0)) < DEPTH);
      ch   = -1;
      if (can)
        for (int k = 1; k <= NCH; k++)
          if (ch < 0 && m_en[(base + k) % NCH]) ch = (base + k) % NCH;
      if (ax) begin tagq.push_back(m_sel); m_last = m_sel; end
      if (rx && pre > 0) begin
        m_smp_req = 1; m_smp_dat = t_nco_dat; m_smp_ch = tagq.pop_front();
      end else begin
        if (rx) m_err = 1;
        if (i_smp_ack) m_smp_req = 0;
      end
      if (ch >= 0) begin m_hold = 1; m_sel = ch; m_ang = nacc[ch]; end
      else if (ax) m_hold = 0;
      if (cfg_we) begin m_inc[cfg_ch] = cfg_inc; m_en[cfg_ch] = cfg_en; end
      for (int c = 0; c < NCH; c++) m_acc[c] = nacc[c];
    end
  end

  // ---------------- NCO stub: result = angle ^ DEADBEEF, 3 edges after acceptance ----------------
  bit res_en = 1;
  logic [W-1:0] nq_dat[$];
  int nq_rdy[$];
  always @(posedge clk) begin
    cyc++;
    #2;
    if (rst_seen) begin
      nq_dat.delete(); nq_rdy.delete(); t_nco_req = 1'b0; t_nco_dat = '0;
    end else begin
      if (ax_seen) begin nq_dat.push_back(ax_dat ^ 32'hDEADBEEF); nq_rdy.push_back(cyc + 2); end
      if (rx_seen && nq_dat.size() > 0) begin void'(nq_dat.pop_front()); void'(nq_rdy.pop_front()); end
      if (t_nco_req && !rx_seen) begin
        t_nco_req = 1'b1;
      end else if (nq_dat.size() > 0 && nq_rdy[0] <= cyc && res_en) begin
        t_nco_req = 1'b1; t_nco_dat = nq_dat[0];
      end else begin
        t_nco_req = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg(input int c, input logic [31:0] inc, input bit e, input bit clr);
    cfg_we = 1; cfg_ch = CW'(c); cfg_inc = inc; cfg_en = e; cfg_clr = clr;
    step(1);
    cfg_we = 0; cfg_clr = 0;
  endtask

  task automatic do_reset();
    reset = 1; cfg_we = 0;
    step(1);
    reset = 0;
    ang_log.delete(); ang_cyc.delete(); smp_ch_log.delete(); smp_dat_log.delete();
  endtask

  task automatic wait_logs(input int na, input int ns);
    int t = 0;
    while ((ang_log.size() < na || smp_ch_log.size() < ns) && t < 200) begin @(negedge clk); t++; end
    chk("wait_logs", 32'(ang_log.size() >= na && smp_ch_log.size() >= ns), 1);
    step(1);
  endtask

  task automatic drain();
    int t = 0;
    for (int c = 0; c < NCH; c++) cfg(c, 32'h0, 0, 0);
    while (t < 400 && (i_angle_req || i_smp_req || t_nco_req || nq_dat.size() != 0)) begin step(1); t++; end
    chk("drain_done", 32'(t < 400), 1);
  endtask

  logic [31:0] exp1 [4] = '{32'h0, 32'h56789abc, 32'hacf13578, 32'h0369d034};
  logic [31:0] exp2 [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
  int idx, t;

  initial begin
    step(2);
    reset = 0;
    @(negedge clk);
    chk("rst_angle_req", i_angle_req, 0);
    chk("rst_angle_dat", i_angle_dat, 0);
    chk("rst_smp_req", i_smp_req, 0);
    chk("rst_err", err, 0);
    chk("rst_t_nco_ack", t_nco_ack, 1);

    // single channel, wrapping accumulator
    step(1);
    cfg(0, 32'h56789abc, 1, 0);
    @(negedge clk); chk("en_lat_n", i_angle_req, 0);
    @(negedge clk); chk("en_lat_n1", i_angle_req, 1);
    wait_logs(4, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_angle", ang_log[k], exp1[k]);
      chk("t1_consec", 32'(ang_cyc[k]), 32'(ang_cyc[0] + k));
      chk("t1_smp_dat", smp_dat_log[k], exp1[k] ^ 32'hDEADBEEF);
      chk("t1_smp_ch", 32'(smp_ch_log[k]), 0);
    end

    // four channels round robin
    do_reset();
    for (int c = 0; c < NCH; c++) cfg(c, 32'(c + 1), 1, 0);
    wait_logs(8, 8);
    for (int k = 0; k < 8; k++) begin
      chk("t2_angle", ang_log[k], exp2[k]);
      chk("t2_smp_ch", 32'(smp_ch_log[k]), 32'(k % NCH));
    end

    // credit limit with results withheld
    do_reset();
    res_en = 0;
    cfg(0, 32'h10, 1, 0);
    step(20);
    chk("credit_count", 32'(ang_log.size()), 8);
    @(negedge clk); chk("credit_stop", i_angle_req, 0);
    step(1);
    res_en = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!(t_nco_req && t_nco_ack) && t < 20);
    chk("first_pop_seen", 32'(t < 20), 1);
    @(negedge clk); chk("resume_same_edge", i_angle_req, 1);
    step(1);
    drain();

    // angle stall with clear of the held channel
    do_reset();
    cfg(0, 32'h100, 1, 0);
    step(6);
    i_angle_ack = 0;
    idx = ang_log.size();
    step(2);
    cfg(0, 32'h100, 1, 1);
    step(2);
    i_angle_ack = 1;
    wait_logs(idx + 2, 0);
    chk("stall_held", ang_log[idx], 32'(idx * 32'h100));
    chk("stall_next", ang_log[idx + 1], 32'h100);
    drain();

    // sample backpressure
    do_reset();
    cfg(0, 32'h1, 1, 0);
    step(3);
    i_smp_ack = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!i_smp_req && t < 20);
    chk("bp_smp_req", i_smp_req, 1);
    chk("bp_t_nco_ack", t_nco_ack, 0);
    step(6);
    i_smp_ack = 1;
    drain();
    chk("bp_count", 32'(smp_dat_log.size()), 32'(ang_log.size()));
    for (int k = 0; k < ang_log.size() && k < smp_dat_log.size(); k++) begin
      chk("bp_angle", ang_log[k], 32'(k));
      chk("bp_smp", smp_dat_log[k], ang_log[k] ^ 32'hDEADBEEF);
    end

    // spurious result, sticky err, mid-stream reset
    do_reset();
    step(2);
    nq_dat.push_back(32'h12345678); nq_rdy.push_back(0);
    t = 0;
    do begin @(negedge clk); t++; end while (!err && t < 10);
    chk("err_set", err, 1);
    chk("err_no_smp", i_smp_req, 0);
    step(1);
    cfg(0, 32'h3, 1, 0);
    step(10);
    chk("err_sticky", err, 1);
    chk("stream_live", i_angle_req, 1);
    reset = 1;
    step(1);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_angle_req", i_angle_req, 0);
    chk("mid_rst_angle_dat", i_angle_dat, 0);
    chk("mid_rst_smp_req", i_smp_req, 0);
    chk("mid_rst_smp_dat", i_smp_dat, 0);
    chk("mid_rst_smp_ch", 32'(i_smp_ch), 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_t_nco_ack", t_nco_ack, 1);

    // random traffic
    step(1);
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      i_angle_ack = ($urandom_range(0, 3) != 0);
      i_smp_ack   = ($urandom_range(0, 3) != 0);
      res_en      = ($urandom_range(0, 3) != 0);
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_ch      = CW'($urandom_range(0, NCH - 1));
      cfg_inc     = $urandom;
      cfg_en      = ($urandom_range(0, 3) != 0);
      cfg_clr     = ($urandom_range(0, 3) == 0);
      step(1);
    end
    cfg_we = 0; cfg_clr = 0; i_angle_ack = 1; i_smp_ack = 1; res_en = 1;
    drain();
    chk("rand_count", 32'(smp_dat_log.size()), 32'(ang_log.size()));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end
endmodule
